video_stream_src: RTL and testbench

VIDEO_STREAM_SRC -- requirements
Module: video_stream_src

---
 rtl/video_stream_src.sv | 214 +++++++++++++++++++++
 tb/tb_video_stream_src.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_src.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : video_stream_src                                              |
// | Purpose  : Converts timed video (VS/DE/RGB888) into a valid/ready pixel  |
// |            stream with an active-low frame sync. Measures the input      |
// |            resolution and counts pixels lost to backpressure.            |
// | Option   : define VIDEO_STREAM_SRC_RES_MEAS_EN to build the resolution   |
// |            measurement; without it xres/yres report DEFAULT_XRES and     |
// |            DEFAULT_YRES and res_valid follows reset.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module video_stream_src #(
  parameter int   SYNC_LEN     = 4,
  parameter logic VS_POL       = 1'b1,
  parameter int   DEFAULT_XRES = 1920,
  parameter int   DEFAULT_YRES = 1080
) (
  input  logic        vin_clk,
  input  logic        rst,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic [23:0] vid_dat,
  output logic [23:0] pix_dat,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_sync_n,
  output logic [15:0] xres,
  output logic [15:0] yres,
  output logic        res_valid,
  output logic [15:0] ovf_cnt
);

  // Last count value of the SYNC phase; the phase lasts SYNC_LEN cycles.
  localparam logic [7:0] c_SYNC_LAST = 8'(SYNC_LEN - 1);

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_SYNC    = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  // Input capture and VS edge detection
  logic        vs_q;
  logic        de_q;
  logic [23:0] dat_q;
  logic        in_vld_q;   // vs_q holds a real sample (not the reset value)
  logic        vs_idle_q;  // previous registered VS sample was inactive
  logic        w_vs_act;
  logic        w_vs_start;

  // Stream FSM
  state_t      state_q, state_d;
  logic [7:0]  sync_cnt_q, sync_cnt_d;
  logic        pix_valid_q, pix_valid_d;
  logic [23:0] pix_dat_q, pix_dat_d;
  logic [15:0] ovf_q, ovf_d;
  logic [15:0] w_ovf_inc;

  // Register the timed video inputs once on entry.
  always_ff @(posedge vin_clk or posedge rst) begin
    if (rst) begin
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      dat_q     <= 24'd0;
      in_vld_q  <= 1'b0;
      vs_idle_q <= 1'b0;
    end else begin
      vs_q      <= vid_vs;
      de_q      <= vid_de;
      dat_q     <= vid_dat;
      in_vld_q  <= 1'b1;
      vs_idle_q <= in_vld_q & ~w_vs_act;
    end
  end

  // A start event needs a genuinely sampled inactive cycle before the active
  // one, so a VS already asserted when reset releases does not trigger it.
  assign w_vs_act   = (vs_q == VS_POL);
  assign w_vs_start = in_vld_q & w_vs_act & vs_idle_q;

  assign w_ovf_inc  = (ovf_q == 16'hFFFF) ? ovf_q : (ovf_q + 16'd1);

  // State, sync counter and stream output registers.
  always_ff @(posedge vin_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_VS;
      sync_cnt_q  <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_dat_q   <= 24'd0;
      ovf_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_dat_q   <= pix_dat_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state and output decode; a VS start event overrides everything and
  // also suppresses any pixel registered in the same cycle.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    pix_valid_d = 1'b0;
    pix_dat_d   = pix_dat_q;
    ovf_d       = ovf_q;
    if (w_vs_start) begin
      state_d    = ST_SYNC;
      sync_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_WAIT_VS: begin
          state_d = ST_WAIT_VS;
        end
        ST_SYNC: begin
          if (sync_cnt_q == c_SYNC_LAST) begin
            state_d = ST_ACTIVE;
          end else begin
            sync_cnt_d = sync_cnt_q + 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (de_q) begin
            if (pix_ready) begin
              pix_valid_d = 1'b1;
              pix_dat_d   = dat_q;
            end else begin
              state_d = ST_DROP;
              ovf_d   = w_ovf_inc;
            end
          end
        end
        ST_DROP: begin
          if (de_q) begin
            ovf_d = w_ovf_inc;
          end
        end
        default: begin
          state_d = ST_WAIT_VS;
        end
      endcase
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_dat      = pix_dat_q;
  assign ovf_cnt      = ovf_q;
  assign frame_sync_n = (state_q != ST_SYNC);

`ifdef VIDEO_STREAM_SRC_RES_MEAS_EN
  logic        de_prev_q;
  logic [15:0] width_q, width_d;
  logic [15:0] lines_q, lines_d;
  logic [15:0] xres_q, xres_d;
  logic [15:0] yres_q, yres_d;
  logic        res_valid_q, res_valid_d;

  // Measurement counters and latched resolution.
  always_ff @(posedge vin_clk or posedge rst) begin
    if (rst) begin
      de_prev_q   <= 1'b0;
      width_q     <= 16'd0;
      lines_q     <= 16'd0;
      xres_q      <= 16'd0;
      yres_q      <= 16'd0;
      res_valid_q <= 1'b0;
    end else begin
      de_prev_q   <= de_q;
      width_q     <= width_d;
      lines_q     <= lines_d;
      xres_q      <= xres_d;
      yres_q      <= yres_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Width restarts on each DE rising edge, so at a VS start event it holds
  // the last run, including a line cut short by that event.
  always_comb begin
    width_d     = width_q;
    lines_d     = lines_q;
    xres_d      = xres_q;
    yres_d      = yres_q;
    res_valid_d = res_valid_q;
    if (w_vs_start) begin
      xres_d      = width_q;
      yres_d      = lines_q;
      res_valid_d = (width_q == xres_q) && (lines_q == yres_q) &&
                    (width_q != 16'd0) && (lines_q != 16'd0);
      width_d     = 16'd0;
      lines_d     = 16'd0;
    end else if (de_q) begin
      if (!de_prev_q) begin
        width_d = 16'd1;
        lines_d = (lines_q == 16'hFFFF) ? lines_q : (lines_q + 16'd1);
      end else begin
        width_d = (width_q == 16'hFFFF) ? width_q : (width_q + 16'd1);
      end
    end
  end

  assign xres      = xres_q;
  assign yres      = yres_q;
  assign res_valid = res_valid_q;
`else
  assign xres      = 16'(DEFAULT_XRES);
  assign yres      = 16'(DEFAULT_YRES);
  assign res_valid = ~rst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_stream_src.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_video_stream_src                                           |
// | Purpose  : Directed self-checking bench for video_stream_src.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_video_stream_src;

  logic        vin_clk = 1'b0;
  logic        rst;
  logic        vid_vs;
  logic        vid_de;
  logic [23:0] vid_dat;
  logic [23:0] pix_dat;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_sync_n;
  logic [15:0] xres;
  logic [15:0] yres;
  logic        res_valid;
  logic [15:0] ovf_cnt;

`ifdef VIDEO_STREAM_SRC_RES_MEAS_EN
  localparam logic [15:0] X_RST = 16'd0;
  localparam logic [15:0] Y_RST = 16'd0;
`else
  localparam logic [15:0] X_RST = 16'd1920;
  localparam logic [15:0] Y_RST = 16'd1080;
`endif
  localparam logic [9:0] FSN_PAT = 10'b1111100001;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          sync_emit = 0;
  logic [23:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [23:0] cap_q[$];
  int          cap_cyc_q[$];
  logic [9:0]  pat;
  int          bad;

  video_stream_src #(
    .SYNC_LEN    (4),
    .VS_POL      (1'b1),
    .DEFAULT_XRES(1920),
    .DEFAULT_YRES(1080)
  ) dut (
    .vin_clk     (vin_clk),
    .rst         (rst),
    .vid_vs      (vid_vs),
    .vid_de      (vid_de),
    .vid_dat     (vid_dat),
    .pix_dat     (pix_dat),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_sync_n(frame_sync_n),
    .xres        (xres),
    .yres        (yres),
    .res_valid   (res_valid),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 vin_clk = ~vin_clk;

  always @(posedge vin_clk) cyc <= cyc + 1;

  // Capture emitted pixels with their cycle number, away from the active edge.
  always @(negedge vin_clk) begin
    if (pix_valid === 1'b1) begin
      cap_q.push_back(pix_dat);
      cap_cyc_q.push_back(cyc);
      if (frame_sync_n === 1'b0) sync_emit++;
    end
  end

  task automatic tick();
    @(posedge vin_clk);
    #1;
  endtask

  task automatic clear_stream();
    exp_q.delete();
    exp_cyc_q.delete();
    cap_q.delete();
    cap_cyc_q.delete();
    sync_emit = 0;
  endtask

  // Index of the first captured pixel whose value or cycle differs, or -1.
  function automatic int first_bad();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (cap_q[i] !== exp_q[i] || cap_cyc_q[i] != exp_cyc_q[i]) return i;
    end
    return -1;
  endfunction

  // VS pulse of two cycles; fsn[j-1] is frame_sync_n seen j edges later.
  task automatic send_vs(input bit sync_de, output logic [9:0] fsn);
    vid_vs    = 1'b1;
    vid_de    = 1'b0;
    pix_ready = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      fsn[j-1] = frame_sync_n;
      if (j == 2) vid_vs = 1'b0;
      if (sync_de && (j == 2 || j == 3)) begin
        vid_de  = 1'b1;
        vid_dat = 24'hEE0000 + 24'(j);
      end else begin
        vid_de = 1'b0;
      end
    end
  endtask

  // Frame of h lines (last line last_w wide); pixel index 'drop' meets
  // pix_ready=0 while registered. Expected pixels queue with latency 2.
  task automatic send_frame(input int w, input int h, input int last_w,
                            input int drop, input int tail, input logic [7:0] fid);
    int prev_id;
    int id;
    int lw;
    prev_id = -1;
    id      = 0;
    for (int l = 0; l < h; l++) begin
      lw = (l == h - 1) ? last_w : w;
      for (int x = 0; x < lw; x++) begin
        vid_de    = 1'b1;
        vid_dat   = {fid, 8'(l), 8'(x)};
        pix_ready = !(drop >= 0 && prev_id == drop);
        if (drop < 0 || id < drop) begin
          exp_q.push_back(vid_dat);
          exp_cyc_q.push_back(cyc + 2);
        end
        prev_id = id;
        id++;
        tick();
      end
      if (l != h - 1) begin
        for (int g = 0; g < 3; g++) begin
          vid_de    = 1'b0;
          pix_ready = !(drop >= 0 && prev_id == drop);
          prev_id   = -1;
          tick();
        end
      end
    end
    for (int t = 0; t < tail; t++) begin
      vid_de    = 1'b0;
      pix_ready = !(drop >= 0 && prev_id == drop);
      prev_id   = -1;
      tick();
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vid_vs = 1'b0; vid_de = 1'b0; vid_dat = 24'd0; pix_ready = 1'b1;
    repeat (3) tick();
    vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b expected 0", pix_valid); end
    vectors++; if (pix_dat !== 24'd0) begin miscompares++; $display("FAIL rst_dat: got %0h expected 0", pix_dat); end
    vectors++; if (frame_sync_n !== 1'b1) begin miscompares++; $display("FAIL rst_fsn: got %0b expected 1", frame_sync_n); end
    vectors++; if (ovf_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_ovf: got %0d expected 0", ovf_cnt); end
    vectors++; if (xres !== X_RST || yres !== Y_RST) begin miscompares++; $display("FAIL rst_res: got %0d x %0d expected %0d x %0d", xres, yres, X_RST, Y_RST); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid: got %0b expected 0", res_valid); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_sync();
    send_vs(1'b0, pat);
    vectors++; if (pat !== FSN_PAT) begin miscompares++; $display("FAIL sync_pulse: got %b expected %b", pat, FSN_PAT); end
  endtask

  task automatic test_stream();
    logic [15:0] ex;
    logic [15:0] ey;
    logic        ev;
    for (int f = 1; f <= 3; f++) begin
      clear_stream();
      send_frame(8, 4, 8, -1, 3, 8'(f));
      vectors++; if (cap_q.size() != 32) begin miscompares++; $display("FAIL stream_count f%0d: got %0d expected 32", f, cap_q.size()); end
      bad = first_bad();
      vectors++; if (bad != -1) begin miscompares++; $display("FAIL stream_order f%0d: got %0h@%0d expected %0h@%0d", f, cap_q[bad], cap_cyc_q[bad], exp_q[bad], exp_cyc_q[bad]); end
      vectors++; if (ovf_cnt !== 16'd0) begin miscompares++; $display("FAIL stream_ovf f%0d: got %0d expected 0", f, ovf_cnt); end
      vectors++; if (pix_dat !== {8'(f), 8'd3, 8'd7}) begin miscompares++; $display("FAIL stream_hold f%0d: got %0h expected %0h", f, pix_dat, {8'(f), 8'd3, 8'd7}); end
      send_vs(1'b0, pat);
`ifdef VIDEO_STREAM_SRC_RES_MEAS_EN
      ex = 16'd8; ey = 16'd4; ev = (f >= 2);
`else
      ex = 16'd1920; ey = 16'd1080; ev = 1'b1;
`endif
      vectors++; if (xres !== ex || yres !== ey || res_valid !== ev) begin miscompares++; $display("FAIL stream_meas f%0d: got %0d x %0d v%0b expected %0d x %0d v%0b", f, xres, yres, res_valid, ex, ey, ev); end
    end
  endtask

  task automatic test_meas_change();
    logic [15:0] ex;
    logic        ev;
    clear_stream();
    send_frame(6, 4, 6, -1, 3, 8'd4);
    vectors++; if (cap_q.size() != 24) begin miscompares++; $display("FAIL meas_count: got %0d expected 24", cap_q.size()); end
    send_vs(1'b0, pat);
`ifdef VIDEO_STREAM_SRC_RES_MEAS_EN
    ex = 16'd6; ev = 1'b0;
`else
    ex = 16'd1920; ev = 1'b1;
`endif
    vectors++; if (xres !== ex || res_valid !== ev) begin miscompares++; $display("FAIL meas_change: got %0d v%0b expected %0d v%0b", xres, res_valid, ex, ev); end
  endtask

  task automatic test_backpressure();
    clear_stream();
    send_frame(8, 4, 8, 4, 3, 8'd5);
    vectors++; if (cap_q.size() != 4) begin miscompares++; $display("FAIL bp_count: got %0d expected 4", cap_q.size()); end
    bad = first_bad();
    vectors++; if (bad != -1) begin miscompares++; $display("FAIL bp_order: got %0h expected %0h", cap_q[bad], exp_q[bad]); end
    vectors++; if (ovf_cnt !== 16'd28) begin miscompares++; $display("FAIL bp_ovf: got %0d expected 28", ovf_cnt); end
    send_vs(1'b0, pat);
    clear_stream();
    send_frame(8, 4, 8, -1, 3, 8'd6);
    vectors++; if (cap_q.size() != 32) begin miscompares++; $display("FAIL bp_recover_count: got %0d expected 32", cap_q.size()); end
    bad = first_bad();
    vectors++; if (bad != -1) begin miscompares++; $display("FAIL bp_recover_order: got %0h expected %0h", cap_q[bad], exp_q[bad]); end
    vectors++; if (ovf_cnt !== 16'd28) begin miscompares++; $display("FAIL bp_recover_ovf: got %0d expected 28", ovf_cnt); end
    send_vs(1'b0, pat);
  endtask

  task automatic test_midline();
    logic [15:0] ex;
    logic [15:0] ey;
    clear_stream();
    send_frame(8, 2, 3, -1, 0, 8'd7);
    send_vs(1'b1, pat);
    vectors++; if (cap_q.size() != 11) begin miscompares++; $display("FAIL mid_count: got %0d expected 11", cap_q.size()); end
    bad = first_bad();
    vectors++; if (bad != -1) begin miscompares++; $display("FAIL mid_order: got %0h expected %0h", cap_q[bad], exp_q[bad]); end
    vectors++; if (sync_emit != 0) begin miscompares++; $display("FAIL mid_sync_emit: got %0d expected 0", sync_emit); end
    vectors++; if (pat !== FSN_PAT) begin miscompares++; $display("FAIL mid_sync_pulse: got %b expected %b", pat, FSN_PAT); end
    vectors++; if (ovf_cnt !== 16'd28) begin miscompares++; $display("FAIL mid_ovf: got %0d expected 28", ovf_cnt); end
`ifdef VIDEO_STREAM_SRC_RES_MEAS_EN
    ex = 16'd3; ey = 16'd2;
`else
    ex = 16'd1920; ey = 16'd1080;
`endif
    vectors++; if (xres !== ex || yres !== ey) begin miscompares++; $display("FAIL mid_meas: got %0d x %0d expected %0d x %0d", xres, yres, ex, ey); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 4; i++) begin
      vid_de  = 1'b1;
      vid_dat = 24'hA50000 + 24'(i);
      tick();
    end
    vectors++; if (pix_valid !== 1'b1) begin miscompares++; $display("FAIL pre_rst_valid: got %0b expected 1", pix_valid); end
    rst = 1'b1;
    #1;
    vectors++; if (pix_valid !== 1'b0 || pix_dat !== 24'd0) begin miscompares++; $display("FAIL mid_rst_pix: got v%0b %0h expected v0 0", pix_valid, pix_dat); end
    vectors++; if (ovf_cnt !== 16'd0 || frame_sync_n !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ovf_fsn: got %0d/%0b expected 0/1", ovf_cnt, frame_sync_n); end
    vectors++; if (xres !== X_RST || yres !== Y_RST || res_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_res: got %0d x %0d v%0b expected %0d x %0d v0", xres, yres, res_valid, X_RST, Y_RST); end
    tick();
    tick();
    rst = 1'b0;
    clear_stream();
    send_frame(8, 2, 8, -1, 3, 8'd8);
    vectors++; if (cap_q.size() != 0) begin miscompares++; $display("FAIL post_rst_emit: got %0d expected 0", cap_q.size()); end
    vectors++; if (ovf_cnt !== 16'd0) begin miscompares++; $display("FAIL post_rst_ovf: got %0d expected 0", ovf_cnt); end
    send_vs(1'b0, pat);
    vectors++; if (pat !== FSN_PAT) begin miscompares++; $display("FAIL post_rst_sync: got %b expected %b", pat, FSN_PAT); end
    clear_stream();
    send_frame(8, 4, 8, -1, 3, 8'd9);
    vectors++; if (cap_q.size() != 32) begin miscompares++; $display("FAIL post_rst_count: got %0d expected 32", cap_q.size()); end
    bad = first_bad();
    vectors++; if (bad != -1) begin miscompares++; $display("FAIL post_rst_order: got %0h expected %0h", cap_q[bad], exp_q[bad]); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stream();
    test_meas_change();
    test_backpressure();
    test_midline();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
